// File: rtl/deser_pkg.sv
// Shared definitions for the bit deserializer: count-width helper and bit-order encoding.
package deser_pkg;

    // Which end of the word the first received bit lands in.
    typedef enum logic {
        ORDER_LSB = 1'b0,
        ORDER_MSB = 1'b1
    } bit_order_e;

    // Bits needed to hold a count from 0 up to and including w.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/deser_shift.sv
// Word-assembly shifter: places each accepted bit by its index and tracks the fill count.
// The word/cnt_nxt outputs already include a bit accepted this cycle, so the parent can
// emit a word in the same cycle its last bit arrives.
module deser_shift
    import deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    localparam int CW       = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic             clear,
    output logic [WIDTH-1:0] word,
    output logic [CW-1:0]    cnt,
    output logic [CW-1:0]    cnt_nxt
);

    localparam bit_order_e ORDER = (MSB_FIRST != 0) ? ORDER_MSB : ORDER_LSB;

    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    pos;

    assign cnt = cnt_q;

    // Merge the incoming bit into its slot; unwritten slots stay zero so OR-in is enough.
    always_comb begin
        pos     = (ORDER == ORDER_MSB) ? (CW'(WIDTH - 1) - cnt_q) : cnt_q;
        word    = word_q;
        cnt_nxt = cnt_q;
        if (shift_en) begin
            word    = word_q | (WIDTH'(bit_in) << pos);
            cnt_nxt = cnt_q + CW'(1);
        end
        word_d = clear ? '0 : word;
        cnt_d  = clear ? '0 : cnt_nxt;
    end

    // Shifter and count state; a clear on emit restarts the next word from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/bit_deserializer.sv
// Collects a 1-bit valid/ready stream into WIDTH-bit words behind a one-entry output
// register. A flush request pushes out whatever partial word is pending.
module bit_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    localparam int CW       = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic             in_bit,
    input  logic             flush,
    output logic             flush_done,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_cnt
);

    logic             slot_free;
    logic             accept;
    logic             last_bit;
    logic             service;
    logic             emit;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;

    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]    out_cnt_q, out_cnt_d;
    logic             flush_done_q, flush_done_d;

    deser_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .bit_in   (in_bit),
        .clear    (emit),
        .word     (word),
        .cnt      (cnt),
        .cnt_nxt  (cnt_nxt)
    );

    // Handshake: the last bit of a word (or any bit during a flush) needs a free output slot.
    always_comb begin
        slot_free = !out_vld_q | out_rdy;
        last_bit  = (cnt == CW'(WIDTH - 1));
        in_rdy    = flush ? slot_free : (slot_free | !last_bit);
        accept    = in_vld & in_rdy;
        service   = flush & slot_free;
        emit      = (accept & last_bit) | (service & (cnt_nxt != '0));
    end

    // Output slot next-state: load on emit, otherwise drain when the consumer takes the word.
    always_comb begin
        out_vld_d    = out_vld_q;
        out_data_d   = out_data_q;
        out_cnt_d    = out_cnt_q;
        flush_done_d = service;
        if (emit) begin
            out_vld_d  = 1'b1;
            out_data_d = word;
            out_cnt_d  = cnt_nxt;
        end else if (out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    // Output holding register and flush acknowledge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q    <= 1'b0;
            out_data_q   <= '0;
            out_cnt_q    <= '0;
            flush_done_q <= 1'b0;
        end else begin
            out_vld_q    <= out_vld_d;
            out_data_q   <= out_data_d;
            out_cnt_q    <= out_cnt_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign out_vld    = out_vld_q;
    assign out_data   = out_data_q;
    assign out_cnt    = out_cnt_q;
    assign flush_done = flush_done_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed bench: two instances (MSB-first and LSB-first) share one stimulus stream.
module tb_bit_deserializer;

    logic       clk = 1'b0;
    logic       rst, in_vld, in_bit, flush, out_rdy;
    logic       irdy_m, irdy_l, fd_m, fd_l, ov_m, ov_l;
    logic [7:0] od_m, od_l;
    logic [3:0] oc_m, oc_l;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(irdy_m), .in_bit(in_bit),
        .flush(flush), .flush_done(fd_m), .out_vld(ov_m), .out_rdy(out_rdy),
        .out_data(od_m), .out_cnt(oc_m)
    );

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(irdy_l), .in_bit(in_bit),
        .flush(flush), .flush_done(fd_l), .out_vld(ov_l), .out_rdy(out_rdy),
        .out_data(od_l), .out_cnt(oc_l)
    );

    typedef struct {
        logic       rst, vld, b, fl, ordy;
        logic       e_irdy, e_ovld;
        logic [7:0] e_dm, e_dl;
        logic [3:0] e_cnt;
        logic       e_fd;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, v, b, fl, ordy, e_irdy, e_ovld,
                       input logic [7:0] e_dm, e_dl, input logic [3:0] e_cnt, input logic e_fd);
        vec_t t;
        t.rst = r; t.vld = v; t.b = b; t.fl = fl; t.ordy = ordy;
        t.e_irdy = e_irdy; t.e_ovld = e_ovld; t.e_dm = e_dm; t.e_dl = e_dl;
        t.e_cnt = e_cnt; t.e_fd = e_fd;
        tv.push_back(t);
    endtask

    // n accepted bits taken from pat, first bit = pat[7]; outputs expected unchanged.
    task automatic add_bits(input logic [7:0] pat, input int n, input logic ordy, input logic ovld,
                            input logic [7:0] dm, dl, input logic [3:0] cnt);
        for (int k = 0; k < n; k++)
            add(1'b0, 1'b1, pat[7-k], 1'b0, ordy, 1'b1, ovld, dm, dl, cnt, 1'b0);
    endtask

    task automatic idle();
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0);
    endtask

    logic [7:0] em[2], el[2], wm[2], wl[2];
    int         cyc[2];
    int         nw;

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_bit = 1'b0; flush = 1'b0; out_rdy = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("reset out_vld", 32'(ov_m), 32'd0);
        chk("reset out_data", 32'(od_m), 32'd0);
        chk("reset out_cnt", 32'(oc_m), 32'd0);
        chk("reset flush_done", 32'(fd_m), 32'd0);
        rst = 1'b0;

        // basic word, both bit orders
        add_bits(8'b1011_0010, 7, 1'b1, 1'b0, 8'h00, 8'h00, 4'd0);
        add(0, 1, 0, 0, 1, 1, 1, 8'hB2, 8'h4D, 4'd8, 0);
        idle();
        // output hold with back-pressure
        add_bits(8'b1100_1010, 7, 1'b1, 1'b0, 8'h00, 8'h00, 4'd0);
        add(0, 1, 0, 0, 1, 1, 1, 8'hCA, 8'h53, 4'd8, 0);
        add_bits(8'b0111_0001, 7, 1'b0, 1'b1, 8'hCA, 8'h53, 4'd8);
        add(0, 1, 1, 0, 0, 0, 1, 8'hCA, 8'h53, 4'd8, 0);
        add(0, 1, 1, 0, 0, 0, 1, 8'hCA, 8'h53, 4'd8, 0);
        add(0, 1, 1, 0, 1, 1, 1, 8'h71, 8'h8E, 4'd8, 0);
        idle();
        // partial flush, then flush with nothing pending
        add_bits(8'b1110_0000, 3, 1'b1, 1'b0, 8'h00, 8'h00, 4'd0);
        add(0, 0, 0, 1, 1, 1, 1, 8'hE0, 8'h07, 4'd3, 1);
        add(0, 0, 0, 1, 1, 1, 0, 8'h00, 8'h00, 4'd0, 1);
        idle();
        add(0, 0, 0, 1, 1, 1, 0, 8'h00, 8'h00, 4'd0, 1);
        idle();
        // flush coinciding with the last bit of a word
        add_bits(8'b1010_1011, 7, 1'b1, 1'b0, 8'h00, 8'h00, 4'd0);
        add(0, 1, 1, 1, 1, 1, 1, 8'hAB, 8'hD5, 4'd8, 1);
        idle();
        // flush blocked by a held word, then serviced
        add_bits(8'hFF, 7, 1'b1, 1'b0, 8'h00, 8'h00, 4'd0);
        add(0, 1, 1, 0, 1, 1, 1, 8'hFF, 8'hFF, 4'd8, 0);
        add(0, 1, 0, 0, 0, 1, 1, 8'hFF, 8'hFF, 4'd8, 0);
        add(0, 1, 1, 0, 0, 1, 1, 8'hFF, 8'hFF, 4'd8, 0);
        add(0, 1, 1, 1, 0, 0, 1, 8'hFF, 8'hFF, 4'd8, 0);
        add(0, 0, 0, 1, 1, 1, 1, 8'h40, 8'h02, 4'd2, 1);
        idle();
        // reset mid-word with a held word
        add_bits(8'h81, 7, 1'b1, 1'b0, 8'h00, 8'h00, 4'd0);
        add(0, 1, 1, 0, 1, 1, 1, 8'h81, 8'h81, 4'd8, 0);
        add_bits(8'hF8, 5, 1'b0, 1'b1, 8'h81, 8'h81, 4'd8);
        add(1, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 4'd0, 0);
        add_bits(8'h01, 7, 1'b1, 1'b0, 8'h00, 8'h00, 4'd0);
        add(0, 1, 1, 0, 1, 1, 1, 8'h01, 8'h80, 4'd8, 0);
        idle();

        foreach (tv[i]) begin
            rst = tv[i].rst; in_vld = tv[i].vld; in_bit = tv[i].b;
            flush = tv[i].fl; out_rdy = tv[i].ordy;
            #1;
            chk($sformatf("row%0d in_rdy_msb", i), 32'(irdy_m), 32'(tv[i].e_irdy));
            chk($sformatf("row%0d in_rdy_lsb", i), 32'(irdy_l), 32'(tv[i].e_irdy));
            @(posedge clk); #1;
            chk($sformatf("row%0d out_vld", i), 32'(ov_m), 32'(tv[i].e_ovld));
            chk($sformatf("row%0d out_vld_lsb", i), 32'(ov_l), 32'(tv[i].e_ovld));
            chk($sformatf("row%0d flush_done", i), 32'(fd_m), 32'(tv[i].e_fd));
            chk($sformatf("row%0d flush_done_lsb", i), 32'(fd_l), 32'(tv[i].e_fd));
            if (tv[i].e_ovld || tv[i].rst) begin
                chk($sformatf("row%0d out_data_msb", i), 32'(od_m), 32'(tv[i].e_dm));
                chk($sformatf("row%0d out_data_lsb", i), 32'(od_l), 32'(tv[i].e_dl));
                chk($sformatf("row%0d out_cnt", i), 32'(oc_m), 32'(tv[i].e_cnt));
                chk($sformatf("row%0d out_cnt_lsb", i), 32'(oc_l), 32'(tv[i].e_cnt));
            end
        end

        // Back-to-back words with out_rdy high: expect no bubble between them.
        for (int k = 0; k < 16; k++) begin
            em[k/8][7-(k%8)] = (k % 3 == 0);
            el[k/8][k%8]     = (k % 3 == 0);
        end
        nw = 0; cyc[0] = -1; cyc[1] = -1; wm[0] = '0; wm[1] = '0; wl[0] = '0; wl[1] = '0;
        rst = 1'b0; flush = 1'b0; out_rdy = 1'b1;
        for (int c = 0; c < 24; c++) begin
            in_vld = (c < 16);
            in_bit = (c < 16) && (c % 3 == 0);
            @(posedge clk); #1;
            if (ov_m) begin
                if (nw < 2) begin
                    wm[nw] = od_m; wl[nw] = od_l; cyc[nw] = c;
                end
                nw++;
            end
        end
        in_vld = 1'b0;
        chk("b2b word count", 32'(nw), 32'd2);
        chk("b2b first word cycle", 32'(cyc[0]), 32'd7);
        chk("b2b second word cycle", 32'(cyc[1]), 32'd15);
        chk("b2b word0 msb", 32'(wm[0]), 32'(em[0]));
        chk("b2b word1 msb", 32'(wm[1]), 32'(em[1]));
        chk("b2b word0 lsb", 32'(wl[0]), 32'(el[0]));
        chk("b2b word1 lsb", 32'(wl[1]), 32'(el[1]));

        // Flush held high with nothing pending: acknowledge every cycle, no words.
        flush = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("held flush_done c%0d", c), 32'(fd_m), 32'd1);
            chk($sformatf("held flush out_vld c%0d", c), 32'(ov_m), 32'd0);
        end
        flush = 1'b0;
        @(posedge clk); #1;
        chk("flush released flush_done", 32'(fd_m), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
